// File: rtl/serial_subtracter.sv
// Bit-serial N-bit subtracter: d = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUBTRACTER_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtracter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SERIAL_SUBTRACTER_OVF_EN
    output logic             bout,
    output logic             ovf
`else
    output logic             bout
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_rd;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             w_s;
    logic             w_dbit;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_rd_next;

    // Full-subtract cell on the current LSBs plus the shift-in of the new difference bit
    always_comb begin
        w_s       = r_ra[0] ^ r_rb[0];
        w_dbit    = w_s ^ r_br;
        w_br_next = (~r_ra[0] & r_rb[0]) | (~w_s & r_br);
        w_last    = (r_cnt == LAST);
        w_rd_next = r_rd;
        for (int i = 0; i < WIDTH - 1; i++) begin
            w_rd_next[i] = r_rd[i+1];
        end
        w_rd_next[WIDTH-1] = w_dbit;
    end

    // Next-state logic for the IDLE/RUN/DONE handshake
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    // Operand capture, serial datapath and result registers (result only moves on completion)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra   <= {WIDTH{1'b0}};
            r_rb   <= {WIDTH{1'b0}};
            r_rd   <= {WIDTH{1'b0}};
            r_br   <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_d    <= {WIDTH{1'b0}};
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ra  <= a;
                        r_rb  <= b;
                        r_br  <= bin;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_ra  <= r_ra >> 1;
                    r_rb  <= r_rb >> 1;
                    r_br  <= w_br_next;
                    r_rd  <= w_rd_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_d    <= w_rd_next;
                        r_bout <= w_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUBTRACTER_OVF_EN
    logic r_am;
    logic r_bm;
    logic r_ovf;

    // Operand MSBs are kept aside because ra/rb are shifted away during RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_am  <= 1'b0;
            r_bm  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_am <= a[WIDTH-1];
            r_bm <= b[WIDTH-1];
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= (r_am ^ r_bm) & (r_am ^ w_rd_next[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign d    = r_d;
    assign bout = r_bout;

endmodule
